// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU execute stage: opcodes, FSM states, widths.
package cpu_pkg;

  // Default operand/result width; the iterative mul/div runs this many steps.
  localparam int DEF_WIDTH = 16;

  // Opcode encoding, identical to the one produced by the rs1/rs2 operand demux.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Execute-stage control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operating mode of the shared iterative mul/div engine.
  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

endpackage

// File: rtl/alu_exec_seq_if.sv
// Issue/result bus between the operand demux, the execute stage and writeback.
interface alu_exec_seq_if #(parameter int WIDTH = cpu_pkg::DEF_WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_opcode;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  logic             busy;

  // Upstream/writeback side: issues operations and consumes results.
  modport master (
    output in_valid, op_opcode, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, result, result_hi, div_by_zero, busy
  );

  // Execute stage side.
  modport slave (
    input  in_valid, op_opcode, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, result, result_hi, div_by_zero, busy
  );

endinterface

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider sharing one 2*WIDTH shift register.
// MUL: {hi,lo} starts as {0,A}; each step conditionally adds B to hi and shifts right.
// DIV: {rem,quo} starts as {0,A}; each step shifts left and trial-subtracts B.
// done_o is high during the final step; lo_o/hi_o then carry the finished result.
module iter_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  md_mode_e         mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  md_mode_e           mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  logic [2*WIDTH-1:0] step_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     trial_s;

  // One shift-add or shift-subtract step applied to the current accumulator.
  always_comb begin
    step_s  = acc_q;
    sum_s   = {(WIDTH+1){1'b0}};
    trial_s = {(WIDTH+1){1'b0}};
    if (mode_q == MD_MUL) begin
      sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
      step_s = {sum_s, acc_q[WIDTH-1:1]};
    end else begin
      // Partial remainder shifted left by one, minus the divisor; bit WIDTH is the borrow.
      trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      if (!trial_s[WIDTH]) begin
        step_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign lo_o   = step_s[WIDTH-1:0];
  assign hi_o   = step_s[2*WIDTH-1:WIDTH];

  // Load operands on start, then advance one step per cycle until the last step.
  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (start_i) begin
      acc_d  = {{WIDTH{1'b0}}, a_i};
      b_d    = b_i;
      mode_d = mode_i;
      cnt_d  = {CW{1'b0}};
      run_d  = 1'b1;
    end else if (run_q) begin
      acc_d = step_s;
      cnt_d = cnt_q + CW'(1);
      if (done_o) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Engine state registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {(2*WIDTH){1'b0}};
      b_q    <= {WIDTH{1'b0}};
      mode_q <= MD_MUL;
      cnt_q  <= {CW{1'b0}};
      run_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute stage: single-cycle add/sub, iterative unsigned mul/div, valid/ready on both sides.
// Only one operation is in flight; a new one is taken only in IDLE.
module alu_exec_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   addsub_s;
  logic             start_s;
  md_mode_e         md_mode_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH-1:0] md_hi_s;

  // Add/sub datapath; bit WIDTH is the carry (ADD) or the borrow (SUB).
  always_comb begin
    if (bus.op_opcode == OP_SUB) begin
      addsub_s = {1'b0, bus.rs1_val} - {1'b0, bus.rs2_val};
    end else begin
      addsub_s = {1'b0, bus.rs1_val} + {1'b0, bus.rs2_val};
    end
  end

  // Launch the iterative engine for MUL, and for DIV unless the divisor is zero.
  always_comb begin
    start_s   = 1'b0;
    md_mode_s = MD_MUL;
    if (bus.op_opcode == OP_DIV) begin
      md_mode_s = MD_DIV;
    end else begin
      md_mode_s = MD_MUL;
    end
    if ((state_q == ST_IDLE) && bus.in_valid) begin
      start_s = (bus.op_opcode == OP_MUL) ||
                ((bus.op_opcode == OP_DIV) && (bus.rs2_val != {WIDTH{1'b0}}));
    end else begin
      start_s = 1'b0;
    end
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_s),
    .mode_i  (md_mode_s),
    .a_i     (bus.rs1_val),
    .b_i     (bus.rs2_val),
    .done_o  (md_done_s),
    .lo_o    (md_lo_s),
    .hi_o    (md_hi_s)
  );

  // Next-state and result-register update for the IDLE/CALC/DONE control flow.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          case (bus.op_opcode)
            OP_ADD, OP_SUB: begin
              result_d    = addsub_s[WIDTH-1:0];
              result_hi_d = {{(WIDTH-1){1'b0}}, addsub_s[WIDTH]};
              dbz_d       = 1'b0;
              state_d     = ST_DONE;
            end
            OP_MUL: begin
              state_d = ST_CALC;
            end
            OP_DIV: begin
              if (bus.rs2_val == {WIDTH{1'b0}}) begin
                result_d    = {WIDTH{1'b1}};
                result_hi_d = bus.rs1_val;
                dbz_d       = 1'b1;
                state_d     = ST_DONE;
              end else begin
                state_d = ST_CALC;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (md_done_s) begin
          result_d    = md_lo_s;
          result_hi_d = md_hi_s;
          dbz_d       = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears any partial or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: the driver pushes reference results, the monitor checks them.
module tb_alu_exec_seq;
  import cpu_pkg::*;

  localparam int W = DEF_WIDTH;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_seq_if #(.WIDTH(W)) bus ();
  alu_exec_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   accepted    = 0;
  int   handshakes  = 0;
  int   hold_req    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    e = '0;
    e.lat = 1;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.hi  = W'(s[W]);
      end
      OP_SUB: begin
        e.res = a - b;
        e.hi  = (a < b) ? W'(1) : W'(0);
      end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.lat = W + 1;
      end
      default: begin
        if (b == '0) begin
          e.res = '1;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          e.lat = W + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: compares every cycle a result is presented and drives out_ready.
  initial begin
    bit prev_ov;
    prev_ov = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        bus.out_ready = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
          end else begin
            if (!prev_ov) check("latency", 64'(cyc - exp_q[0].acc_cyc + 1), 64'(exp_q[0].lat));
            check("result", 64'(bus.result), 64'(exp_q[0].res));
            check("result_hi", 64'(bus.result_hi), 64'(exp_q[0].hi));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(exp_q[0].dbz));
            check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
            check("busy_in_done", 64'(bus.busy), 64'd1);
          end
        end
        prev_ov = bus.out_valid;
        if (bus.out_valid && hold_req > 0) begin
          hold_req--;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          handshakes++;
        end
      end
    end
  end

  // Issue one op (called at a negedge); optionally wiggle inputs while the op is busy.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
    exp_t e;
    int   guard;
    bus.in_valid  = 1'b1;
    bus.op_opcode = op;
    bus.rs1_val   = a;
    bus.rs2_val   = b;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    accepted++;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || guard >= 40) break;
      guard++;
      if (junk) begin
        bus.in_valid  = 1'b1;
        bus.op_opcode = 2'($urandom_range(0, 3));
        bus.rs1_val   = W'($urandom);
        bus.rs2_val   = W'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) check("completion_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_result_hi"}, 64'(bus.result_hi), 64'd0);
    check({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  // Stimulus: reset, directed cases, backpressure, mid-op reset, random stream.
  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.op_opcode = 2'd0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    issue(OP_ADD, 16'hFFFF, 16'h0002, 1'b0);
    issue(OP_SUB, 16'h0003, 16'h0005, 1'b0);
    issue(OP_MUL, 16'h1234, 16'h0100, 1'b0);
    issue(OP_DIV, 16'h0064, 16'h0007, 1'b0);
    issue(OP_DIV, 16'h00AB, 16'h0000, 1'b0);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
    issue(OP_DIV, 16'hFFFF, 16'h0001, 1'b0);
    issue(OP_DIV, 16'h0005, 16'h0009, 1'b0);
    issue(OP_ADD, 16'h0000, 16'h0000, 1'b0);
    issue(OP_SUB, 16'h8000, 16'h8000, 1'b0);

    // Backpressure after a MUL while junk is driven on the inputs during CALC.
    wait_drain();
    hold_req = 5;
    issue(OP_MUL, 16'hBEEF, 16'h1357, 1'b1);
    wait_drain();

    // Reset in the middle of a DIV: nothing from it may ever appear.
    bus.in_valid  = 1'b1;
    bus.op_opcode = OP_DIV;
    bus.rs1_val   = 16'h1234;
    bus.rs2_val   = 16'h0007;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid_div", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_div_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_abort", 64'(bus.in_ready), 64'd1);
    repeat (25) @(negedge clk);
    check_all_zero("after_abort");

    // Random back-to-back stream with random out_ready.
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
      issue(rop, ra, rb, ($urandom_range(0, 1) == 1));
    end
    wait_drain();
    check("handshakes_per_op", 64'(handshakes), 64'(accepted));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
